// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit for the EX stage.
// Owns the architectural HI/LO pair. Multiply commits after a fixed number of busy
// cycles. Divide runs a radix-2 restoring loop on operand magnitudes, followed by one
// sign-fix cycle.

module muldiv_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [3:0]       op_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] res_o,
    output logic             res_valid_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [3:0] OpMul  = 4'd1;
    localparam logic [3:0] OpDiv  = 4'd2;
    localparam logic [3:0] OpMadd = 4'd3;
    localparam logic [3:0] OpMfhi = 4'd4;
    localparam logic [3:0] OpMflo = 4'd5;
    localparam logic [3:0] OpMthi = 4'd6;
    localparam logic [3:0] OpMtlo = 4'd7;
    localparam logic [3:0] OpMsub = 4'd8;

    localparam int unsigned     CntW    = $clog2(WIDTH + MUL_CYCLES + 1);
    localparam logic [CntW-1:0] MulLast = CntW'(MUL_CYCLES - 1);
    localparam logic [CntW-1:0] DivLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StFix
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              res_valid_q, res_valid_d;
    logic              done_q, done_d;
    logic [3:0]        op_q, op_d;
    logic              sgn_q, sgn_d;
    logic [WIDTH-1:0]  opa_q, opa_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    // Divider: quo holds the remaining dividend bits and shifts in quotient bits
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;

    logic              op_known;
    logic              accept;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod, hilo, acc;
    logic [WIDTH:0]    div_sh, div_trial;
    logic [WIDTH-1:0]  quo_fix, rem_fix;

    assign op_ready_o  = (state_q == StIdle) && reset_n;
    assign res_o       = res_q;
    assign res_valid_o = res_valid_q;
    assign done_o      = done_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;

    // Operand conditioning, product, accumulate and one restoring divide step
    always_comb begin
        op_known = (op_i >= OpMul) && (op_i <= OpMsub);
        accept   = op_valid_i && op_ready_o && op_known && !flush_i;

        a_mag = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
        b_mag = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

        // Extending to 2*WIDTH before multiplying gives the exact product mod 2^(2*WIDTH)
        ext_a = {{WIDTH{sgn_q & opa_q[WIDTH-1]}}, opa_q};
        ext_b = {{WIDTH{sgn_q & opb_q[WIDTH-1]}}, opb_q};
        prod  = ext_a * ext_b;
        hilo  = {hi_q, lo_q};
        if (op_q == OpMadd) begin
            acc = hilo + prod;
        end else if (op_q == OpMsub) begin
            acc = hilo - prod;
        end else begin
            acc = prod;
        end

        div_sh    = {rem_q, quo_q[WIDTH-1]};
        div_trial = div_sh - {1'b0, dvs_q};

        quo_fix = qneg_q ? -quo_q : quo_q;
        rem_fix = rneg_q ? -rem_q : rem_q;
    end

    // Next-state logic: sequencing, operand capture, HI/LO commit
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        res_d       = res_q;
        res_valid_d = 1'b0;
        done_d      = 1'b0;
        op_d        = op_q;
        sgn_d       = sgn_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (op_i)
                        OpMul, OpMadd, OpMsub: begin
                            state_d = StMul;
                            cnt_d   = '0;
                            op_d    = op_i;
                            sgn_d   = signed_i;
                            opa_d   = a_i;
                            opb_d   = b_i;
                        end
                        OpDiv: begin
                            state_d = StDiv;
                            cnt_d   = '0;
                            op_d    = op_i;
                            sgn_d   = signed_i;
                            opa_d   = a_i;
                            opb_d   = b_i;
                            quo_d   = a_mag;
                            rem_d   = '0;
                            dvs_d   = b_mag;
                            qneg_d  = signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                            rneg_d  = signed_i && a_i[WIDTH-1];
                        end
                        OpMfhi: begin
                            res_d       = hi_q;
                            res_valid_d = 1'b1;
                        end
                        OpMflo: begin
                            res_d       = lo_q;
                            res_valid_d = 1'b1;
                        end
                        OpMthi: hi_d = a_i;
                        OpMtlo: lo_d = a_i;
                        default: ;
                    endcase
                end
            end
            StMul: begin
                if (flush_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == MulLast) begin
                    {hi_d, lo_d} = acc;
                    done_d       = 1'b1;
                    state_d      = StIdle;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDiv: begin
                if (flush_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    // Restore (keep shifted remainder) when the trial subtract borrows
                    if (!div_trial[WIDTH]) begin
                        rem_d = div_trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = div_sh[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_q == DivLast) begin
                        state_d = StFix;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                cnt_d   = '0;
                if (!flush_i) begin
                    done_d = 1'b1;
                    if (opb_q == '0) begin
                        lo_d = '1;
                        hi_d = opa_q;
                    end else begin
                        // MIN / -1 falls out naturally: magnitude 2^(W-1), no negation
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            op_q        <= '0;
            sgn_q       <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            done_q      <= done_d;
            op_q        <= op_d;
            sgn_q       <= sgn_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32, MUL_CYCLES=2).
// HI/LO reference is kept as plain 64-bit integer arithmetic.

module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [3:0]  op = 4'd0;
    logic        signed_in = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic [31:0] res;
    logic        res_valid;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    muldiv_unit #(
        .WIDTH      (32),
        .MUL_CYCLES (2)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .op_valid_i  (op_valid),
        .op_ready_o  (op_ready),
        .op_i        (op),
        .signed_i    (signed_in),
        .a_i         (a),
        .b_i         (b),
        .flush_i     (flush),
        .res_o       (res),
        .res_valid_o (res_valid),
        .done_o      (done),
        .hi_o        (hi),
        .lo_o        (lo)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: updates hi_m/lo_m and tells what the DUT should show
    task automatic model_op(input logic [3:0] o, input logic s, input logic [31:0] x,
                            input logic [31:0] y, output logic [31:0] rv,
                            output logic is_res, output int busy, output logic is_arith);
        longint      ix, iy;
        logic [63:0] p, acc, q, r;
        ix = s ? longint'($signed(x)) : longint'(x);
        iy = s ? longint'($signed(y)) : longint'(y);
        rv = '0;
        is_res = 1'b0;
        busy = 0;
        is_arith = 1'b0;
        case (o)
            4'd1, 4'd3, 4'd8: begin
                p   = 64'(ix * iy);
                acc = {hi_m, lo_m};
                if (o == 4'd1)      acc = p;
                else if (o == 4'd3) acc = acc + p;
                else                acc = acc - p;
                hi_m = acc[63:32];
                lo_m = acc[31:0];
                busy = 2;
                is_arith = 1'b1;
            end
            4'd2: begin
                if (y == 32'd0) begin
                    lo_m = 32'hFFFF_FFFF;
                    hi_m = x;
                end else begin
                    q = 64'(ix / iy);
                    r = 64'(ix % iy);
                    lo_m = q[31:0];
                    hi_m = r[31:0];
                end
                busy = 33;
                is_arith = 1'b1;
            end
            4'd4: begin rv = hi_m; is_res = 1'b1; end
            4'd5: begin rv = lo_m; is_res = 1'b1; end
            4'd6: hi_m = x;
            4'd7: lo_m = x;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [3:0] o, input logic s, input logic [31:0] x,
                          input logic [31:0] y);
        logic [31:0] rv;
        logic        is_res, is_arith;
        int          busy, cycles, busy_dones;
        @(negedge clock);
        check("done_low_before", done, 1'b0);
        check("resv_low_before", res_valid, 1'b0);
        check("ready_before", op_ready, 1'b1);
        op_valid = 1'b1;
        op = o;
        signed_in = s;
        a = x;
        b = y;
        model_op(o, s, x, y, rv, is_res, busy, is_arith);
        @(posedge clock);
        #1;
        // Scramble inputs after acceptance; the unit must have latched them
        op_valid = 1'b0;
        op = 4'($urandom);
        signed_in = 1'($urandom);
        a = $urandom;
        b = $urandom;
        @(negedge clock);
        check("res_valid", res_valid, is_res);
        if (is_res) check("res", res, rv);
        cycles = 0;
        busy_dones = 0;
        while (!op_ready && cycles < 100) begin
            if (done) busy_dones++;
            cycles++;
            @(negedge clock);
        end
        check("busy_cycles", cycles, busy);
        check("done_while_busy", busy_dones, 0);
        check("done_pulse", done, is_arith);
        check("hi", hi, hi_m);
        check("lo", lo, lo_m);
    endtask

    initial begin
        logic [3:0]  ro;
        logic [31:0] ra, rb;
        logic [3:0]  op_tbl [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};

        // Reset state
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_ready", op_ready, 1'b0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_res", res, 32'd0);
        check("rst_resv", res_valid, 1'b0);
        check("rst_done", done, 1'b0);
        reset_n = 1'b1;
        @(negedge clock);
        check("ready_after_rst", op_ready, 1'b1);

        // Move-to / move-from round trip
        run_op(4'd6, 1'b0, 32'h1234_5678, 32'd0);
        run_op(4'd7, 1'b0, 32'h9ABC_DEF0, 32'd0);
        run_op(4'd4, 1'b0, 32'd0, 32'd0);
        check("mfhi_const", res, 32'h1234_5678);
        run_op(4'd5, 1'b0, 32'd0, 32'd0);
        check("mflo_const", res, 32'h9ABC_DEF0);

        // Multiply
        run_op(4'd1, 1'b1, 32'hFFFF_FFFD, 32'd7);
        check("muls_hi", hi, 32'hFFFF_FFFF);
        check("muls_lo", lo, 32'hFFFF_FFEB);
        run_op(4'd1, 1'b0, 32'hFFFF_FFFD, 32'd7);
        check("mulu_hi", hi, 32'h0000_0006);
        check("mulu_lo", lo, 32'hFFFF_FFEB);

        // Divide
        run_op(4'd2, 1'b1, 32'hFFFF_FFF9, 32'd2);
        check("divs_lo", lo, 32'hFFFF_FFFD);
        check("divs_hi", hi, 32'hFFFF_FFFF);
        run_op(4'd2, 1'b0, 32'd100, 32'd7);
        check("divu_lo", lo, 32'h0000_000E);
        check("divu_hi", hi, 32'h0000_0002);
        run_op(4'd2, 1'b0, 32'h55, 32'd0);
        check("div0_lo", lo, 32'hFFFF_FFFF);
        check("div0_hi", hi, 32'h55);
        run_op(4'd2, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check("divmin_lo", lo, 32'h8000_0000);
        check("divmin_hi", hi, 32'd0);

        // Accumulate
        run_op(4'd6, 1'b0, 32'd0, 32'd0);
        run_op(4'd7, 1'b0, 32'hFFFF_FFFF, 32'd0);
        run_op(4'd3, 1'b0, 32'd1, 32'd1);
        check("madd_hi", hi, 32'd1);
        check("madd_lo", lo, 32'd0);
        run_op(4'd8, 1'b1, 32'd2, 32'd3);
        check("msub_hi", hi, 32'd0);
        check("msub_lo", lo, 32'hFFFF_FFFA);

        // Flush in idle blocks acceptance; opcode 9 behaves as NONE
        @(negedge clock);
        op_valid = 1'b1; op = 4'd6; a = 32'hDEAD_BEEF; flush = 1'b1;
        @(negedge clock);
        op_valid = 1'b0; flush = 1'b0;
        check("idle_flush_hi", hi, hi_m);
        op_valid = 1'b1; op = 4'd9; a = 32'hCAFE_0000;
        @(negedge clock);
        op_valid = 1'b0;
        check("op9_ready", op_ready, 1'b1);
        check("op9_resv", res_valid, 1'b0);
        check("op9_hi", hi, hi_m);
        check("op9_lo", lo, lo_m);

        // Randomized mix against the reference
        for (int i = 0; i < 40; i++) begin
            ro = op_tbl[$urandom_range(0, 7)];
            case ($urandom_range(0, 3))
                0: ra = 32'h8000_0000;
                1: ra = $urandom_range(0, 200);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            run_op(ro, 1'($urandom), ra, rb);
        end

        // Flush mid-divide
        run_op(4'd6, 1'b0, 32'hA, 32'd0);
        run_op(4'd7, 1'b0, 32'hB, 32'd0);
        @(negedge clock);
        op_valid = 1'b1; op = 4'd2; signed_in = 1'b0; a = 32'd50; b = 32'd5;
        @(posedge clock);
        #1;
        op_valid = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clock);
        check("flush_busy", op_ready, 1'b0);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_ready", op_ready, 1'b1);
        check("flush_done", done, 1'b0);
        check("flush_hi", hi, 32'hA);
        check("flush_lo", lo, 32'hB);
        begin
            int late_dones = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clock);
                if (done) late_dones++;
            end
            check("flush_late_done", late_dones, 0);
            check("flush_late_lo", lo, 32'hB);
        end

        // Reset mid-divide
        @(negedge clock);
        op_valid = 1'b1; op = 4'd2; signed_in = 1'b0; a = 32'd50; b = 32'd5;
        @(posedge clock);
        #1;
        op_valid = 1'b0;
        repeat (5) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midrst_ready_low", op_ready, 1'b0);
        @(negedge clock);
        hi_m = '0;
        lo_m = '0;
        check("midrst_ready", op_ready, 1'b0);
        check("midrst_hi", hi, hi_m);
        check("midrst_lo", lo, lo_m);
        check("midrst_done", done, 1'b0);
        reset_n = 1'b1;
        @(negedge clock);
        check("midrst_ready_after", op_ready, 1'b1);
        begin
            int late_dones = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clock);
                if (done) late_dones++;
            end
            check("midrst_late_done", late_dones, 0);
            check("midrst_late_lo", lo, 32'd0);
        end

        // Unit still works after reset
        run_op(4'd1, 1'b0, 32'd6, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
